spi_main: RTL and testbench

- SPI main (controller) that drives the same four-wire link that `spi_secondary` receives on: `neg_enable`, `sck`, `out_bit` (MOSI) and `in_bit` (MISO).
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, full duplex: each word sent also captures one received word.
- Used as the host-side link driver in board-level loopback and bring-up builds, and as the bench stimulus generator for `spi_secondary`.
- A word-level handshake on the bus side lets the user chain words under one chip-select assertion.

---
 rtl/spi_main_if.sv | 23 ++
 rtl/spi_main.sv | 155 +++++++++++++++
 tb/tb_spi_main.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_main_if.sv
// Word-level bus between the user logic and the SPI main controller.
// The user side takes the master modport; spi_main takes the slave modport.
interface spi_main_if #(
  parameter int WORD_BITS = 8
);
  logic                 start;
  logic                 keep_selected;
  logic                 finish;
  logic [WORD_BITS-1:0] data_word_to_send;
  logic                 ready;
  logic                 word_ready;
  logic [WORD_BITS-1:0] data_word_received;

  modport master (
    output start, keep_selected, finish, data_word_to_send,
    input  ready, word_ready, data_word_received
  );

  modport slave (
    input  start, keep_selected, finish, data_word_to_send,
    output ready, word_ready, data_word_received
  );
endinterface

// File: rtl/spi_main.sv
// SPI main, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
// Each half SCK period lasts CLK_DIV clk cycles. A word may leave chip
// select asserted so that the next word follows under the same selection.
module spi_main #(
  parameter int WORD_BITS = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  spi_main_if.slave   bus,
  output logic        neg_enable,
  output logic        sck,
  output logic        out_bit,
  input  logic        in_bit
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_TRAIL, S_GAP, S_CHAINED
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic [WORD_BITS-1:0] rx_q, rx_d;
  logic [WORD_BITS-1:0] drx_q, drx_d;
  logic                 keep_q, keep_d;
  logic                 ne_q, ne_d;
  logic                 sck_q, sck_d;
  logic                 ob_q, ob_d;
  logic                 rdy_q, rdy_d;
  logic                 wr_q, wr_d;
  logic                 half_done;

  assign half_done              = (div_q == DIV_LAST);
  assign neg_enable             = ne_q;
  assign sck                    = sck_q;
  assign out_bit                = ob_q;
  assign bus.ready              = rdy_q;
  assign bus.word_ready         = wr_q;
  assign bus.data_word_received = drx_q;

  // State and output registers; reset drops the link immediately, even mid-word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      drx_q   <= '0;
      keep_q  <= 1'b0;
      ne_q    <= 1'b1;
      sck_q   <= 1'b0;
      ob_q    <= 1'b0;
      rdy_q   <= 1'b1;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      drx_q   <= drx_d;
      keep_q  <= keep_d;
      ne_q    <= ne_d;
      sck_q   <= sck_d;
      ob_q    <= ob_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state and next-output logic; timed states advance on half_done.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    drx_d   = drx_q;
    keep_d  = keep_q;
    ne_d    = ne_q;
    sck_d   = sck_q;
    ob_d    = ob_q;
    rdy_d   = rdy_q;
    wr_d    = 1'b0;

    if (state_q != S_IDLE && state_q != S_CHAINED)
      div_d = half_done ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE, S_CHAINED: begin
        // start beats finish; in CHAINED the chip select is already low
        if (bus.start) begin
          tx_d    = bus.data_word_to_send;
          keep_d  = bus.keep_selected;
          rx_d    = '0;
          bit_d   = BIT_TOP;
          ne_d    = 1'b0;
          ob_d    = bus.data_word_to_send[WORD_BITS-1];
          rdy_d   = 1'b0;
          state_d = S_SETUP;
        end else if (state_q == S_CHAINED && bus.finish) begin
          ne_d    = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_SETUP, S_LOW: begin
        if (half_done) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[WORD_BITS-2:0], in_bit};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (half_done) begin
          sck_d = 1'b0;
          if (bit_q == '0) begin
            state_d = S_TRAIL;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            ob_d    = tx_q[bit_d];
            state_d = S_LOW;
          end
        end
      end
      S_TRAIL: begin
        if (half_done) begin
          drx_d = rx_q;
          wr_d  = 1'b1;
          if (keep_q) begin
            rdy_d   = 1'b1;
            state_d = S_CHAINED;
          end else begin
            ne_d    = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (half_done) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_main.sv
// Bench for spi_main: two instances (8-bit/div 2 against a secondary model,
// 16-bit/div 1 in MOSI->MISO loopback) compared every cycle against a
// cycle-count model, plus directed literal expectations.
module tb_spi_main;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_main_if #(.WORD_BITS(8))  bus_a ();
  spi_main_if #(.WORD_BITS(16)) bus_b ();
  logic ne_a, sck_a, ob_a, ib_a;
  logic ne_b, sck_b, ob_b, ib_b;

  spi_main #(.WORD_BITS(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .neg_enable(ne_a), .sck(sck_a), .out_bit(ob_a), .in_bit(ib_a));
  spi_main #(.WORD_BITS(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .neg_enable(ne_b), .sck(sck_b), .out_bit(ob_b), .in_bit(ib_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: elapsed cycles since accept ----------
  localparam int M_IDLE = 0, M_WORD = 1, M_CHAIN = 2, M_GAP = 3;
  typedef struct {
    int          mode;
    int          k;
    logic [15:0] tx, resp, rx;
    logic        keep, ne, sck, ob, rdy, wr;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.k = 0; m.tx = '0; m.resp = '0; m.rx = '0;
    m.keep = 1'b0; m.ne = 1'b1; m.sck = 1'b0; m.ob = 1'b0; m.rdy = 1'b1; m.wr = 1'b0;
    return m;
  endfunction

  // k = cycles since chip select went low; half-period index h = k / d.
  // Even h: sck low; odd h: sck high; bit h/2 is on MOSI while h < 2w.
  function automatic mdl_t mdl_step(input mdl_t mi, input int w, input int d,
                                    input logic st, input logic ks, input logic fin,
                                    input logic [15:0] data, input logic [15:0] resp);
    mdl_t m;
    int h;
    m = mi;
    m.wr = 1'b0;
    case (m.mode)
      M_IDLE, M_CHAIN: begin
        if (st) begin
          m.mode = M_WORD; m.k = 0; m.tx = data; m.resp = resp; m.keep = ks;
          m.ne = 1'b0; m.rdy = 1'b0; m.sck = 1'b0; m.ob = data[w-1];
        end else if (m.mode == M_CHAIN && fin) begin
          m.mode = M_GAP; m.k = 0; m.ne = 1'b1; m.rdy = 1'b0;
        end
      end
      M_WORD: begin
        m.k++;
        h = m.k / d;
        if (m.k == (2*w + 1) * d) begin
          m.wr = 1'b1; m.rx = m.resp; m.sck = 1'b0;
          if (m.keep) begin
            m.mode = M_CHAIN; m.rdy = 1'b1;
          end else begin
            m.mode = M_GAP; m.k = 0; m.ne = 1'b1;
          end
        end else begin
          m.sck = (h % 2 == 1);
          if (h < 2*w) m.ob = m.tx[w - 1 - h/2];
        end
      end
      default: begin
        m.k++;
        if (m.k == d) begin
          m.mode = M_IDLE; m.rdy = 1'b1;
        end
      end
    endcase
    return m;
  endfunction

  mdl_t ma, mb;
  logic [7:0] sec_resp_a;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, 8, 2, bus_a.start, bus_a.keep_selected, bus_a.finish,
                     {8'h00, bus_a.data_word_to_send}, {8'h00, sec_resp_a});
      mb <= mdl_step(mb, 16, 1, bus_b.start, bus_b.keep_selected, bus_b.finish,
                     bus_b.data_word_to_send, bus_b.data_word_to_send);
    end
  end

  // ---------------- secondary model for dut_a, loopback for dut_b ----------
  logic [2:0] falls_a = '0;
  logic       prev_sck_a = 1'b0;
  int         rises_a = 0, wr_cnt_a = 0, ne_hi_a = 0;
  logic [15:0] mosi_a = '0;

  assign ib_a = sec_resp_a[3'd7 - falls_a];
  assign ib_b = ob_b;

  // MISO shifts after each SCK fall; record MOSI at each SCK rise.
  always @(negedge clk) begin
    prev_sck_a <= sck_a;
    if (ne_a) falls_a <= '0;
    else if (prev_sck_a && !sck_a) falls_a <= falls_a + 3'd1;
    if (!prev_sck_a && sck_a) begin
      rises_a <= rises_a + 1;
      mosi_a  <= {mosi_a[14:0], ob_a};
    end
    wr_cnt_a <= wr_cnt_a + int'(bus_a.word_ready);
    ne_hi_a  <= ne_hi_a + int'(ne_a);
  end

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clk) begin
    chk("a.neg_enable", ne_a, ma.ne);
    chk("a.sck", sck_a, ma.sck);
    chk("a.out_bit", ob_a, ma.ob);
    chk("a.ready", bus_a.ready, ma.rdy);
    chk("a.word_ready", bus_a.word_ready, ma.wr);
    chk("a.rx", bus_a.data_word_received, ma.rx[7:0]);
    chk("b.neg_enable", ne_b, mb.ne);
    chk("b.sck", sck_b, mb.sck);
    chk("b.out_bit", ob_b, mb.ob);
    chk("b.ready", bus_b.ready, mb.rdy);
    chk("b.word_ready", bus_b.word_ready, mb.wr);
    chk("b.rx", bus_b.data_word_received, mb.rx);
  end

  // ---------------- directed + random stimulus -----------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accept edge; n = cycle offset of word_ready.
  task automatic wait_wr(input bit which, output int n);
    n = 1;
    @(negedge clk);
    while (!(which ? bus_b.word_ready : bus_a.word_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "wait_wr_b" : "wait_wr_a",
        which ? bus_b.word_ready : bus_a.word_ready, 1);
  endtask

  task automatic start_a(input logic [7:0] d, input logic ks, input logic [7:0] resp);
    sec_resp_a = resp;
    bus_a.data_word_to_send = d;
    bus_a.keep_selected = ks;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.data_word_to_send = ~d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, r0, w0, h0;
    rst = 1'b1;
    sec_resp_a = '0;
    bus_a.start = 0; bus_a.keep_selected = 0; bus_a.finish = 0; bus_a.data_word_to_send = '0;
    bus_b.start = 0; bus_b.keep_selected = 0; bus_b.finish = 0; bus_b.data_word_to_send = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.neg_enable", ne_a, 1);
    chk("rst.sck", sck_a, 0);
    chk("rst.out_bit", ob_a, 0);
    chk("rst.ready", bus_a.ready, 1);
    chk("rst.word_ready", bus_a.word_ready, 0);
    chk("rst.rx", bus_a.data_word_received, 0);
    rst = 1'b0;
    tick();

    // 1: single word 0xA5, secondary answers 0x3C
    r0 = rises_a;
    start_a(8'hA5, 1'b0, 8'h3C);
    wait_wr(1'b0, n);
    chk("t1.latency", n, 35);
    chk("t1.rx", bus_a.data_word_received, 8'h3C);
    chk("t1.mosi", mosi_a[7:0], 8'hA5);
    chk("t1.rises", rises_a - r0, 8);
    g = 0;
    while (!bus_a.ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("t1.gap", g, 2);
    tick();

    // 2: chained 0x01 then 0x80, released only by finish
    r0 = rises_a; w0 = wr_cnt_a;
    start_a(8'h01, 1'b1, 8'h5A);
    h0 = ne_hi_a;
    wait_wr(1'b0, n);
    chk("t2.rx0", bus_a.data_word_received, 8'h5A);
    repeat (3) tick();
    start_a(8'h80, 1'b1, 8'hC3);
    wait_wr(1'b0, n);
    chk("t2.latency", n, 35);
    chk("t2.rx1", bus_a.data_word_received, 8'hC3);
    repeat (3) tick();
    chk("t2.rises", rises_a - r0, 16);
    chk("t2.words", wr_cnt_a - w0, 2);
    chk("t2.cs_held", ne_hi_a - h0, 0);
    chk("t2.mosi", mosi_a, 16'h0180);
    chk("t2.cs_low", ne_a, 0);
    bus_a.finish = 1'b1;
    tick();
    bus_a.finish = 1'b0;
    chk("t2.release", ne_a, 1);
    repeat (4) tick();

    // 6: start and finish together in CHAINED -> start wins
    start_a(8'h11, 1'b1, 8'h99);
    wait_wr(1'b0, n);
    tick();
    sec_resp_a = 8'h66;
    bus_a.data_word_to_send = 8'h42;
    bus_a.keep_selected = 1'b0;
    bus_a.start = 1'b1;
    bus_a.finish = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.finish = 1'b0;
    h0 = ne_hi_a;
    wait_wr(1'b0, n);
    chk("t6.latency", n, 35);
    chk("t6.cs_held", ne_hi_a - h0, 0);
    chk("t6.mosi", mosi_a[7:0], 8'h42);
    chk("t6.rx", bus_a.data_word_received, 8'h66);
    repeat (4) tick();

    // 3: start hammered during a transfer of 0xFF
    r0 = rises_a; w0 = wr_cnt_a;
    start_a(8'hFF, 1'b0, 8'hE7);
    g = 0;
    while (!ma.rdy && g < 200) begin
      bus_a.start = 1'b1;
      bus_a.data_word_to_send = 8'($urandom);
      bus_a.keep_selected = 1'($urandom);
      tick();
      g++;
    end
    bus_a.start = 1'b0;
    chk("t3.busy_len", g, 36);
    repeat (5) tick();
    chk("t3.words", wr_cnt_a - w0, 1);
    chk("t3.rises", rises_a - r0, 8);
    chk("t3.rx", bus_a.data_word_received, 8'hE7);
    chk("t3.idle_cs", ne_a, 1);

    // 4: reset after three SCK rises of 0x55
    r0 = rises_a; w0 = wr_cnt_a;
    start_a(8'h55, 1'b0, 8'h0F);
    g = 0;
    while (rises_a - r0 < 3 && g < 100) begin
      @(negedge clk);
      g++;
    end
    #2 rst = 1'b1;
    #1;
    chk("t4.neg_enable", ne_a, 1);
    chk("t4.sck", sck_a, 0);
    chk("t4.out_bit", ob_a, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t4.no_word", wr_cnt_a - w0, 0);
    r0 = rises_a;
    start_a(8'h5A, 1'b0, 8'hA3);
    wait_wr(1'b0, n);
    chk("t4.latency", n, 35);
    chk("t4.rx", bus_a.data_word_received, 8'hA3);
    chk("t4.mosi", mosi_a[7:0], 8'h5A);
    chk("t4.rises", rises_a - r0, 8);
    repeat (4) tick();

    // 5: 16-bit loopback at CLK_DIV=1
    bus_b.data_word_to_send = 16'hBEEF;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    bus_b.data_word_to_send = 16'h0000;
    wait_wr(1'b1, n);
    chk("t5.latency", n, 34);
    chk("t5.rx", bus_b.data_word_received, 16'hBEEF);
    repeat (4) tick();

    // random traffic on both instances, checked by the per-cycle compare
    repeat (1500) begin
      bus_a.start = ($urandom_range(3) == 0);
      bus_a.keep_selected = 1'($urandom);
      bus_a.finish = ($urandom_range(7) == 0);
      bus_a.data_word_to_send = 8'($urandom);
      if (ma.rdy) sec_resp_a = 8'($urandom);
      bus_b.start = ($urandom_range(3) == 0);
      bus_b.keep_selected = 1'($urandom);
      bus_b.finish = ($urandom_range(7) == 0);
      bus_b.data_word_to_send = 16'($urandom);
      tick();
    end
    bus_a.start = 0; bus_a.finish = 0;
    bus_b.start = 0; bus_b.finish = 0;
    repeat (60) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
